// File: rtl/tdc_dma.sv
// tdc_dma: buffers TDC timestamps in a small FIFO and writes them into a memory ring over Wishbone.
// Latency: a word reaches the bus two edges after its strobe; each word takes 3 cycles with a zero-wait ack.
// Backpressure: none on ev_stb_i; a full FIFO drops the word and sets sticky overflow.
// Ports: sys_clk/sys_rst_n clock and async active-low reset; csr_* register bank (read data registered);
//        ev_stb_i/ev_data_i timestamp input; wbm_* classic Wishbone write master; irq level interrupt.
module tdc_dma #(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         fifo_depth = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        ev_stb_i,
  input  logic [31:0] ev_data_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        irq
);
  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(fifo_depth);
  localparam logic [AW:0]   L_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  // Reset deassertion is brought onto sys_clk before the FSM may start a bus cycle.
  logic [1:0] r_sync;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_sync <= 2'b00;
    else            r_sync <= {r_sync[0], 1'b1};
  end

  // Register bank
  logic [1:0]  r_ctrl;
  logic [29:0] r_base;
  logic [15:0] r_size, r_wrptr, r_rdptr;
  logic        r_ovf;
  logic [31:0] r_csr_do;
  logic        w_sel, w_wr, w_ptr_clr, w_stat_clr;
  logic [31:0] w_rd;

  assign w_sel      = (csr_a[13:10] == csr_addr);
  assign w_wr       = csr_we & w_sel;
  assign w_ptr_clr  = w_wr & ((csr_a[2:0] == 3'd1) | (csr_a[2:0] == 3'd2));
  assign w_stat_clr = w_wr & (csr_a[2:0] == 3'd5) & csr_di[0];

  // Event FIFO; a pop in the same cycle frees the slot a full-FIFO push needs.
  logic [31:0]   r_mem [fifo_depth];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_empty, w_full, w_pop, w_push, w_drop;
  logic [4:0]    w_level;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == L_DEPTH);
  assign w_pop   = (r_state == S_WRITE) & wbm_ack_i;
  assign w_push  = ev_stb_i & (~w_full | w_pop);
  assign w_drop  = ev_stb_i & w_full & ~w_pop;
  assign w_level = 5'(r_cnt);

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wp] <= ev_data_i;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + P_ONE;
      if (w_pop)  r_rp <= r_rp + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + L_ONE;
        2'b01:   r_cnt <= r_cnt - L_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Ring bookkeeping: one slot is kept free so WRPTR==RDPTR always means empty.
  logic [15:0] w_wrptr_inc;
  logic        w_ring_full, w_start;

  assign w_wrptr_inc = (r_wrptr == r_size - 16'd1) ? 16'd0 : r_wrptr + 16'd1;
  assign w_ring_full = (r_size == 16'd0) | (w_wrptr_inc == r_rdptr);
  assign w_start     = (r_state == S_IDLE) & r_sync[1] & r_ctrl[0] & ~w_empty & ~w_ring_full;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_state_nxt = S_WRITE;
      S_WRITE: if (wbm_ack_i) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are latched once at cycle start and held until ack.
  logic        r_cyc;
  logic [31:0] r_adr, r_dat;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cyc <= 1'b0;
      r_adr <= 32'd0;
      r_dat <= 32'd0;
    end else if (w_start) begin
      r_cyc <= 1'b1;
      r_adr <= {r_base, 2'b00} + {14'd0, r_wrptr, 2'b00};
      r_dat <= r_mem[r_rp];
    end else if (w_pop) begin
      r_cyc <= 1'b0;
    end
  end

  always_comb begin
    w_rd = 32'd0;
    case (csr_a[2:0])
      3'd0: w_rd = {30'd0, r_ctrl};
      3'd1: w_rd = {r_base, 2'b00};
      3'd2: w_rd = {16'd0, r_size};
      3'd3: w_rd = {16'd0, r_wrptr};
      3'd4: w_rd = {16'd0, r_rdptr};
      3'd5: w_rd = {23'd0, w_level, 2'b00, (r_state != S_IDLE), r_ovf};
      default: w_rd = 32'd0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ctrl   <= 2'b00;
      r_base   <= 30'd0;
      r_size   <= 16'd0;
      r_wrptr  <= 16'd0;
      r_rdptr  <= 16'd0;
      r_ovf    <= 1'b0;
      r_csr_do <= 32'd0;
    end else begin
      if (w_wr) begin
        case (csr_a[2:0])
          3'd0:    r_ctrl  <= csr_di[1:0];
          3'd1:    r_base  <= csr_di[31:2];
          3'd2:    r_size  <= csr_di[15:0];
          3'd4:    r_rdptr <= csr_di[15:0];
          default: ;
        endcase
      end
      // Re-pointing the ring restarts it; an in-flight cycle keeps its latched address.
      if (w_ptr_clr)  r_wrptr <= 16'd0;
      else if (w_pop) r_wrptr <= w_wrptr_inc;
      // A drop in the same cycle as a clear wins so no loss goes unreported.
      if (w_drop)          r_ovf <= 1'b1;
      else if (w_stat_clr) r_ovf <= 1'b0;
      r_csr_do <= w_sel ? w_rd : 32'd0;
    end
  end

  logic w_unused;
  assign w_unused = ^csr_a[9:3];

  assign csr_do    = r_csr_do;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = 4'hf;
  assign wbm_cti_o = 3'b000;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_cyc;
  assign irq       = r_ctrl[1] & ((r_wrptr != r_rdptr) | r_ovf);
endmodule

// File: tb/tb_tdc_dma.sv
module tb_tdc_dma;
  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        ev_stb_i = 1'b0;
  logic [31:0] ev_data_i = '0;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
  logic        irq;

  tdc_dma #(.csr_addr(4'h2), .fifo_depth(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .ev_stb_i(ev_stb_i), .ev_data_i(ev_data_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_cti_o(wbm_cti_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Wishbone slave: ack after wait_n wait states.
  int wait_n = 0;
  int ack_cnt = 0;
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & (ack_cnt == wait_n);
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ack_cnt <= 0;
    else if (wbm_cyc_o & wbm_stb_o & !wbm_ack_i) ack_cnt <= ack_cnt + 1;
    else ack_cnt <= 0;
  end

  // Behavioural model: FIFO as a queue, ring pointers as plain integers.
  logic [31:0] m_q[$];
  logic [1:0]  m_ctrl;
  logic [29:0] m_base;
  logic [15:0] m_size, m_wrptr, m_rdptr;
  logic        m_ovf, m_done, m_busy, m_ack, m_can;
  logic        prev_cyc, prev_can, mon_on = 1'b0;
  logic [31:0] lat_adr, lat_dat, exp_csr_do;
  logic [31:0] wr_adr[$], wr_dat[$];

  function automatic bit m_ring_full();
    if (m_size == 16'd0) return 1'b1;
    return ((int'(m_wrptr) + 1) % int'(m_size)) == int'(m_rdptr);
  endfunction

  function automatic logic [31:0] m_reg(input logic [2:0] a, input logic b);
    case (a)
      3'd0: return {30'd0, m_ctrl};
      3'd1: return {m_base, 2'b00};
      3'd2: return {16'd0, m_size};
      3'd3: return {16'd0, m_wrptr};
      3'd4: return {16'd0, m_rdptr};
      3'd5: return (32'(m_q.size()) * 32'd16) | {30'd0, b, m_ovf};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_q.delete();
      m_ctrl = 0; m_base = 0; m_size = 0; m_wrptr = 0; m_rdptr = 0; m_ovf = 0;
      m_done = 0; prev_cyc = 0; prev_can = 0; exp_csr_do = 0;
    end else begin
      m_busy = wbm_cyc_o | m_done;
      exp_csr_do = (csr_a[13:10] == 4'h2) ? m_reg(csr_a[2:0], m_busy) : 32'd0;
      m_can = m_ctrl[0] && (m_q.size() > 0) && !m_ring_full();
      m_ack = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
      if (wbm_cyc_o && !prev_cyc) begin
        chk("start_allowed", {31'd0, prev_can}, 32'd1);
        chk("start_fifo_nonempty", {31'd0, m_q.size() > 0}, 32'd1);
        chk("start_adr", wbm_adr_o, {m_base, 2'b00} + 32'(m_wrptr) * 32'd4);
        if (m_q.size() > 0) chk("start_dat", wbm_dat_o, m_q[0]);
        lat_adr = wbm_adr_o;
        lat_dat = wbm_dat_o;
      end else if (wbm_cyc_o) begin
        chk("hold_adr", wbm_adr_o, lat_adr);
        chk("hold_dat", wbm_dat_o, lat_dat);
      end
      if (wbm_cyc_o) chk("stb_we", {30'd0, wbm_stb_o, wbm_we_o}, 32'd3);
      if (m_ack) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        wr_adr.push_back(wbm_adr_o);
        wr_dat.push_back(wbm_dat_o);
        m_wrptr = (m_size == 0) ? 16'd0 : 16'((int'(m_wrptr) + 1) % int'(m_size));
      end
      if (csr_we && csr_a[13:10] == 4'h2) begin
        case (csr_a[2:0])
          3'd0: m_ctrl = csr_di[1:0];
          3'd1: begin m_base = csr_di[31:2]; m_wrptr = 0; end
          3'd2: begin m_size = csr_di[15:0]; m_wrptr = 0; end
          3'd4: m_rdptr = csr_di[15:0];
          3'd5: if (csr_di[0]) m_ovf = 0;
          default: ;
        endcase
      end
      if (ev_stb_i) begin
        if (m_q.size() < DEPTH) m_q.push_back(ev_data_i);
        else m_ovf = 1;
      end
      m_done = m_ack;
      prev_cyc = wbm_cyc_o;
      prev_can = m_can;
    end
  end

  always @(negedge sys_clk) begin
    if (mon_on && sys_rst_n) begin
      chk("csr_do", csr_do, exp_csr_do);
      chk("irq", {31'd0, irq}, {31'd0, m_ctrl[1] && ((m_wrptr != m_rdptr) || m_ovf)});
      if (wbm_cyc_o) chk("sel_cti", {25'd0, wbm_sel_o, wbm_cti_o}, {25'd0, 4'hf, 3'b000});
    end
  end

  // Stimulus tasks: called and returning at a falling edge.
  function automatic logic [13:0] ra(input int r);
    return {4'h2, 7'd0, 3'(r)};
  endfunction

  task automatic csr_wr(input int r, input logic [31:0] d);
    csr_a = ra(r); csr_di = d; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input int r, output logic [31:0] d);
    csr_a = ra(r);
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic ev(input logic [31:0] d);
    ev_stb_i = 1'b1; ev_data_i = d;
    @(negedge sys_clk);
    ev_stb_i = 1'b0;
  endtask

  task automatic wait_cyc(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      @(negedge sys_clk);
      if (wbm_cyc_o) break;
    end
  endtask

  task automatic do_reset();
    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int n0, cyc_n;
    bit acked;
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_csr_do", csr_do, 32'd0);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    for (int r = 0; r < 6; r++) begin
      csr_rd(r, d);
      chk($sformatf("rst_reg%0d", r), d, 32'd0);
    end

    // Basic single write
    csr_wr(1, 32'h4000_0100);
    csr_wr(2, 32'd8);
    csr_wr(0, 32'd1);
    ev(32'hDEAD_BEEF);
    wait_cyc(20);
    chk("t1_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    chk("t1_adr", wbm_adr_o, 32'h4000_0100);
    chk("t1_dat", wbm_dat_o, 32'hDEAD_BEEF);
    chk("t1_sel", {28'd0, wbm_sel_o}, 32'hf);
    @(negedge sys_clk);
    chk("t1_cyc_end", {31'd0, wbm_cyc_o}, 32'd0);
    @(negedge sys_clk);
    csr_rd(5, d); chk("t1_stat_idle", d, 32'd0);
    csr_rd(3, d); chk("t1_wrptr", d, 32'd1);
    chk("t1_nwrites", wr_adr.size(), 32'd1);

    // Wrap and ring full
    csr_wr(2, 32'd4);
    csr_wr(4, 32'd0);
    n0 = wr_adr.size();
    for (int i = 0; i < 6; i++) begin
      ev_stb_i = 1'b1; ev_data_i = 32'h1000 + i;
      @(negedge sys_clk);
    end
    ev_stb_i = 1'b0;
    repeat (30) @(negedge sys_clk);
    chk("t2_nwrites", wr_adr.size() - n0, 32'd3);
    chk("t2_off0", wr_adr[n0] - 32'h4000_0100, 32'h0);
    chk("t2_off1", wr_adr[n0+1] - 32'h4000_0100, 32'h4);
    chk("t2_off2", wr_adr[n0+2] - 32'h4000_0100, 32'h8);
    chk("t2_dat0", wr_dat[n0], 32'h1000);
    csr_rd(3, d); chk("t2_wrptr", d, 32'd3);
    csr_rd(5, d); chk("t2_stat_level3", d, 32'h30);
    csr_wr(4, 32'd2);
    repeat (20) @(negedge sys_clk);
    chk("t2_nwrites_resume", wr_adr.size() - n0, 32'd5);
    chk("t2_off3", wr_adr[n0+3] - 32'h4000_0100, 32'hC);
    chk("t2_off4", wr_adr[n0+4] - 32'h4000_0100, 32'h0);
    csr_rd(3, d); chk("t2_wrptr_wrap", d, 32'd1);

    // Overflow with the engine disabled
    do_reset();
    csr_wr(0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      ev_stb_i = 1'b1; ev_data_i = 32'h3000 + i;
      @(negedge sys_clk);
    end
    ev_stb_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    csr_rd(5, d); chk("t3_stat_ovf", d, 32'h41);
    chk("t3_irq_off", {31'd0, irq}, 32'd0);
    csr_wr(0, 32'd2);
    chk("t3_irq_on", {31'd0, irq}, 32'd1);
    csr_wr(5, 32'd1);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);
    csr_rd(5, d); chk("t3_stat_clr", d, 32'h40);

    // Wait states, disable mid-cycle, push/pop on full FIFO
    csr_wr(1, 32'h2000);
    csr_wr(2, 32'd16);
    wait_n = 5;
    n0 = wr_adr.size();
    csr_wr(0, 32'd1);
    wait_cyc(10);
    csr_a = ra(0); csr_di = 32'd0; csr_we = 1'b1;
    cyc_n = 0; acked = 0;
    for (int k = 0; k < 12; k++) begin
      if (wbm_cyc_o) cyc_n++;
      if (wbm_ack_i && !acked) begin ev_stb_i = 1'b1; ev_data_i = 32'h3004; acked = 1; end
      @(negedge sys_clk);
      csr_we = 1'b0; ev_stb_i = 1'b0;
      if (acked) break;
    end
    chk("t4_acked", {31'd0, acked}, 32'd1);
    chk("t4_cyc_cycles", cyc_n, 32'd6);
    repeat (10) @(negedge sys_clk);
    chk("t4_no_more", wr_adr.size() - n0, 32'd1);
    chk("t4_adr", wr_adr[n0], 32'h2000);
    chk("t4_dat", wr_dat[n0], 32'h3000);
    csr_rd(5, d); chk("t4_stat_full_noovf", d, 32'h40);
    wait_n = 0;
    csr_wr(0, 32'd1);
    repeat (30) @(negedge sys_clk);
    chk("t4_drain", wr_adr.size() - n0, 32'd5);
    chk("t4_order1", wr_dat[n0+1], 32'h3001);
    chk("t4_order4", wr_dat[n0+4], 32'h3004);
    chk("t4_adr4", wr_adr[n0+4], 32'h2010);

    // Reset in the middle of a bus cycle
    wait_n = 5;
    n0 = wr_adr.size();
    ev(32'h5555_5555);
    wait_cyc(10);
    chk("t5_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t5_cyc_async", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    chk("t5_adr_async", wbm_adr_o, 32'd0);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    wait_n = 0;
    @(negedge sys_clk);
    for (int r = 0; r < 6; r++) begin
      csr_rd(r, d);
      chk($sformatf("t5_reg%0d", r), d, 32'd0);
    end
    cyc_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (wbm_cyc_o) cyc_n++;
    end
    chk("t5_no_bus", cyc_n, 32'd0);
    chk("t5_no_writes", wr_adr.size() - n0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
